apb_slave_mem: RTL and testbench



---
 rtl/apb_slave_mem_if.sv | 26 ++
 rtl/apb_slave_mem.sv | 188 ++++++++++++++++++
 tb/tb_apb_slave_mem.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between the bridge (master) and apb_slave_mem (slave).
// Signal names follow the completer's point of view: *_i are driven by the
// master and *_o by the slave.
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  psel_i;
  logic                  penable_i;
  logic                  pwrite_i;
  logic [ADDR_WIDTH-1:0] paddr_i;
  logic [DATA_WIDTH-1:0] pwdata_i;
  logic [DATA_WIDTH-1:0] prdata_o;
  logic                  pready_o;
  logic                  pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB3 completer backed by a word-addressed register array.
// A SETUP phase samples the address, direction and write data, checks the
// address window and alignment, then the ACCESS phase waits a fixed number
// of cycles before one registered pready/pslverr pulse. Writes commit on the
// completion cycle; reads are captured at SETUP. All outputs come from flops.
// Optional macro APB_SLV_RANDOM_WAIT_EN: per-transfer wait count drawn from a
// 16-bit Galois LFSR masked by WAIT_CYCLES instead of the fixed WAIT_CYCLES.
module apb_slave_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_LG2   = 6,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                    WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           rst_n,
  apb_slave_mem_if.slave s_apb
);

  localparam int DEPTH   = 1 << DEPTH_LG2;
  localparam int IDX_LSB = 2;
  localparam int IDX_MSB = DEPTH_LG2 + 1;
  localparam int WIN_LSB = DEPTH_LG2 + 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // FSM and output registers
  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic                  r_pready;
  logic                  w_pready_nxt;
  logic                  r_pslverr;
  logic                  w_pslverr_nxt;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [DATA_WIDTH-1:0] w_prdata_nxt;

  // Transfer attributes captured at SETUP
  logic                  r_write;
  logic                  r_err;
  logic [DEPTH_LG2-1:0]  r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;

  // Storage
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Decode of the live bus
  logic                  w_setup;
  logic                  w_accept;
  logic                  w_err_in;
  logic [DEPTH_LG2-1:0]  w_idx_in;
  logic [3:0]            w_wait_load;
  logic                  w_commit;

  assign w_setup  = s_apb.psel_i & ~s_apb.penable_i;
  // IDLE and DONE both accept a new SETUP, which is what allows back-to-back
  // transfers without an idle cycle after pready.
  assign w_accept = (r_state != ST_ACCESS) & w_setup;
  assign w_idx_in = s_apb.paddr_i[IDX_MSB:IDX_LSB];
  // BASE_ADDR is aligned to the window size, so the window test reduces to
  // comparing the bits above the index field.
  assign w_err_in = (s_apb.paddr_i[1:0] != 2'b00) |
                    (s_apb.paddr_i[ADDR_WIDTH-1:WIN_LSB] != BASE_ADDR[ADDR_WIDTH-1:WIN_LSB]);

`ifdef APB_SLV_RANDOM_WAIT_EN
  logic [15:0] r_lfsr;

  // Galois LFSR (x^16+x^14+x^13+x^11+1), stepped once per accepted SETUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 16'hACE1;
    end else if (w_accept) begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign w_wait_load = r_lfsr[3:0] & 4'(WAIT_CYCLES);
`else
  assign w_wait_load = 4'(WAIT_CYCLES);
`endif

  // Next-state and next-output logic for the transfer FSM
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value unassigned and infer a latch.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pready_nxt  = 1'b0;
    w_pslverr_nxt = 1'b0;
    w_prdata_nxt  = r_prdata;
    w_commit      = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        // penable without a prior SETUP lands here and is ignored.
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          w_state_nxt = ST_ACCESS;
          w_cnt_nxt   = w_wait_load;
          // Zero wait states: the completion pulse is in the first ACCESS cycle.
          if (w_wait_load == 4'd0) begin
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = w_err_in;
          end
          if (!s_apb.pwrite_i) begin
            w_prdata_nxt = w_err_in ? '0 : r_mem[w_idx_in];
          end
        end
      end

      ST_ACCESS: begin
        if (!s_apb.psel_i) begin
          // Master abort: drop the transfer silently, nothing is written.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt != 4'd0) begin
          if (s_apb.penable_i) begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              w_pready_nxt  = 1'b1;
              w_pslverr_nxt = r_err;
            end
          end
        end else begin
          // Counter at zero means pready is high this cycle: finish up.
          w_state_nxt = ST_DONE;
          w_commit    = r_write & ~r_err;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter, output and SETUP-capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_prdata  <= w_prdata_nxt;
      if (w_accept) begin
        r_write <= s_apb.pwrite_i;
        r_err   <= w_err_in;
        r_idx   <= w_idx_in;
        r_wdata <= s_apb.pwdata_i;
      end
    end
  end

  // Storage array: cleared by reset, written on a successful write completion
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the array is deliberately reset because reads after reset must
    // return zero; this forces flops rather than a RAM macro.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign s_apb.prdata_o  = r_prdata;
  assign s_apb.pready_o  = r_pready;
  assign s_apb.pslverr_o = r_pslverr;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed self-checking bench for apb_slave_mem. Two instances share one
// stimulus bus: u_dut_w2 (WAIT_CYCLES=2) and u_dut_w0 (WAIT_CYCLES=0); 'sel'
// routes psel to one of them and muxes its outputs back.
// With APB_SLV_RANDOM_WAIT_EN defined, latency checks become range checks and
// a 100-read random-latency run is added.
module tb_apb_slave_mem;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_w2 ();
  apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_w0 ();

  apb_slave_mem #(.WAIT_CYCLES(2)) u_dut_w2 (.clk(clk), .rst_n(rst_n), .s_apb(if_w2));
  apb_slave_mem #(.WAIT_CYCLES(0)) u_dut_w0 (.clk(clk), .rst_n(rst_n), .s_apb(if_w0));

  assign if_w2.psel_i    = psel & ~sel;
  assign if_w2.penable_i = penable;
  assign if_w2.pwrite_i  = pwrite;
  assign if_w2.paddr_i   = paddr;
  assign if_w2.pwdata_i  = pwdata;
  assign if_w0.psel_i    = psel & sel;
  assign if_w0.penable_i = penable;
  assign if_w0.pwrite_i  = pwrite;
  assign if_w0.paddr_i   = paddr;
  assign if_w0.pwdata_i  = pwdata;

  assign prdata  = sel ? if_w0.prdata_o  : if_w2.prdata_o;
  assign pready  = sel ? if_w0.pready_o  : if_w2.pready_o;
  assign pslverr = sel ? if_w0.pslverr_o : if_w2.pslverr_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Exact latency normally; with random waits only the upper bound is known.
  task automatic check_lat(input string tag, input int lat, input int exp);
`ifdef APB_SLV_RANDOM_WAIT_EN
    check(tag, 32'((lat >= 1) && (lat <= exp)), 32'd1);
`else
    check(tag, 32'(lat), 32'(exp));
`endif
  endtask

  // One APB transfer; entered and left #1 after a rising edge. lat counts
  // ACCESS cycles up to and including the pready cycle.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 1;
    while (pready !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = prdata;
    er = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    rst_n = 1'b0; sel = 1'b0; psel = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0;
    #3;
    check("rst_prdata",  prdata,          32'h0);
    check("rst_pready",  32'(pready),     32'h0);
    check("rst_pslverr", 32'(pslverr),    32'h0);
    check("rst_w0_rdy",  32'(if_w0.pready_o), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read 0x10, two wait states
    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
    check("wr10_err", 32'(er), 32'h0);
    check_lat("wr10_lat", lat, 3);
    check("wr10_rdy_drop", 32'(pready), 32'h0);
    xfer(1'b0, 32'h10, 32'h0, rd, er, lat);
    check("rd10_data", rd, 32'hDEAD_BEEF);
    check("rd10_err", 32'(er), 32'h0);
    check_lat("rd10_lat", lat, 3);

    // Zero wait states, back-to-back writes then reads
    sel = 1'b1;
    xfer(1'b1, 32'h0, 32'h1111_1111, rd, er, lat);
    check_lat("w0_wr0_lat", lat, 1);
    xfer(1'b1, 32'h4, 32'h2222_2222, rd, er, lat);
    check_lat("w0_wr4_lat", lat, 1);
    xfer(1'b1, 32'h8, 32'h3333_3333, rd, er, lat);
    check_lat("w0_wr8_lat", lat, 1);
    check("w0_wr8_err", 32'(er), 32'h0);
    xfer(1'b0, 32'h0, 32'h0, rd, er, lat);
    check("w0_rd0_data", rd, 32'h1111_1111);
    check_lat("w0_rd0_lat", lat, 1);
    xfer(1'b0, 32'h4, 32'h0, rd, er, lat);
    check("w0_rd4_data", rd, 32'h2222_2222);
    xfer(1'b0, 32'h8, 32'h0, rd, er, lat);
    check("w0_rd8_data", rd, 32'h3333_3333);
    sel = 1'b0;

    // Out-of-window access: 0x100 would alias word 0 if the window were ignored
    xfer(1'b1, 32'h100, 32'hAAAA_5555, rd, er, lat);
    check("oow_wr_err", 32'(er), 32'h1);
    xfer(1'b0, 32'h100, 32'h0, rd, er, lat);
    check("oow_rd_err", 32'(er), 32'h1);
    check("oow_rd_data", rd, 32'h0);
    xfer(1'b0, 32'h0, 32'h0, rd, er, lat);
    check("oow_word0", rd, 32'h0);
    check("oow_word0_err", 32'(er), 32'h0);

    // Unaligned access to 0x6 must not touch word 1
    xfer(1'b1, 32'h4, 32'hCAFE_F00D, rd, er, lat);
    xfer(1'b1, 32'h6, 32'h0BAD_BAD0, rd, er, lat);
    check("unal_wr_err", 32'(er), 32'h1);
    xfer(1'b0, 32'h4, 32'h0, rd, er, lat);
    check("unal_word1", rd, 32'hCAFE_F00D);
    xfer(1'b0, 32'h6, 32'h0, rd, er, lat);
    check("unal_rd_err", 32'(er), 32'h1);
    check("unal_rd_data", rd, 32'h0);

    // penable without SETUP is ignored
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h4;
    repeat (4) begin
      @(posedge clk); #1;
      check("noset_rdy", 32'(pready), 32'h0);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;

`ifndef APB_SLV_RANDOM_WAIT_EN
    // Master abort in the second wait cycle of a write to 0x20
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h1234;
    @(posedge clk); #1;
    penable = 1'b1;
    check("abort_rdy_w1", 32'(pready), 32'h0);
    @(posedge clk); #1;
    check("abort_rdy_w2", 32'(pready), 32'h0);
    psel = 1'b0; penable = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_rdy_after", 32'(pready), 32'h0);
    end
    xfer(1'b0, 32'h20, 32'h0, rd, er, lat);
    check("abort_rd20", rd, 32'h0);
`endif

    // Asynchronous reset in the middle of a write to 0x10
    xfer(1'b0, 32'h10, 32'h0, rd, er, lat);
    check("pre_rst_rd10", rd, 32'hDEAD_BEEF);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h1234_5678;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
`ifndef APB_SLV_RANDOM_WAIT_EN
    check("mid_rdy_before", 32'(pready), 32'h1);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pready",  32'(pready),  32'h0);
    check("mid_rst_pslverr", 32'(pslverr), 32'h0);
    check("mid_rst_prdata",  prdata,       32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 32'h10, 32'h0, rd, er, lat);
    check("post_rst_rd10", rd, 32'h0);
    xfer(1'b0, 32'h4, 32'h0, rd, er, lat);
    check("post_rst_rd4", rd, 32'h0);

`ifdef APB_SLV_RANDOM_WAIT_EN
    // Random-latency reads against a small set of known words
    for (int k = 0; k < 8; k++) begin
      xfer(1'b1, 32'h40 + 32'(4 * k), 32'h1000_0000 + 32'(k * 32'h0101), rd, er, lat);
    end
    for (int i = 0; i < 100; i++) begin
      int k;
      k = $urandom_range(0, 7);
      xfer(1'b0, 32'h40 + 32'(4 * k), 32'h0, rd, er, lat);
      check("rnd_rd_data", rd, 32'h1000_0000 + 32'(k * 32'h0101));
      check("rnd_rd_lat", 32'((lat >= 1) && (lat <= 16)), 32'd1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
